// File: rtl/secuenciador_instrucciones_if.sv
// Bus between the instruction sequencer and whoever loads/starts it.
// The master side loads the program and controls runs; the slave side
// (the sequencer) presents the instruction word and run status.
interface secuenciador_instrucciones_if #(
  parameter int IW = 21,
  parameter int AW = 5
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          halt;
  logic [IW-1:0] instruccion;
  logic          valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, halt,
    input  instruccion, valid, pc, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, halt,
    output instruccion, valid, pc, busy, done
  );
endinterface

// File: rtl/secuenciador_instrucciones.sv
// Instruction sequencer feeding the ISA datapath. Holds a small writable
// program memory and steps through words 0..len-1, presenting each one for
// HOLD_CYCLES cycles after a one-cycle fetch bubble.
module secuenciador_instrucciones #(
  parameter int IW          = 21,
  parameter int DEPTH       = 32,
  parameter int AW          = 5,
  parameter int HOLD_CYCLES = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  secuenciador_instrucciones_if.slave bus
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [AW:0]   len_reg, len_next;
  logic          done_reg, done_next;

  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] rd_reg;
  logic          mem_we;

  // Writes are only accepted while idle so a running program cannot be
  // modified underneath itself; reset also blocks them.
  assign mem_we = bus.prog_we && (state_reg == IDLE) && !rst;

  // Program memory: synchronous write, registered read during FETCH.
  // The read register is only loaded in FETCH, so the word stays frozen
  // for the whole hold window.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
    if (state_reg == FETCH) begin
      rd_reg <= mem[pc_reg];
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      cnt_reg   <= '0;
      len_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: fetch / hold / advance, with halt taking priority
  // over everything while a run is in progress.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.prog_len == '0) begin
            done_next = 1'b1;
          end else begin
            len_next   = bus.prog_len;
            pc_next    = '0;
            cnt_next   = '0;
            state_next = FETCH;
          end
        end
      end

      FETCH: begin
        if (bus.halt) begin
          state_next = IDLE;
          pc_next    = '0;
          cnt_next   = '0;
        end else begin
          cnt_next   = '0;
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (bus.halt) begin
          state_next = IDLE;
          pc_next    = '0;
          cnt_next   = '0;
        end else if (cnt_reg == CW'(HOLD_CYCLES - 1)) begin
          cnt_next = '0;
          // Compare at AW+1 bits so a full-depth run ends at DEPTH-1
          // instead of wrapping.
          if ({1'b0, pc_reg} == (len_reg - (AW+1)'(1))) begin
            state_next = IDLE;
            pc_next    = '0;
            done_next  = 1'b1;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = FETCH;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        pc_next    = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so they cannot glitch.
  assign bus.instruccion = (state_reg == HOLD) ? rd_reg : '0;
  assign bus.valid       = (state_reg == HOLD);
  assign bus.busy        = (state_reg == FETCH) || (state_reg == HOLD);
  assign bus.pc          = pc_reg;
  assign bus.done        = done_reg;

endmodule
